// File: rtl/key_debounce_module_pkg.sv
// Shared key-handling definitions: debounce FSM state encoding and 50 MHz
// board timing constants, also used by the key edge detector.
package key_debounce_module_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DLY_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DLY_RELEASE = 2'd3
   } key_state_e;

   // Cycle counts minus one at 50 MHz.
   localparam logic [15:0] T1MS_50MHZ          = 16'd49_999;
   localparam logic [15:0] T100US_50MHZ        = 16'd4_999;
   localparam logic [7:0]  DEBOUNCE_MS_DEFAULT = 8'd10;

endpackage

// File: rtl/key_debounce_module_ms_timer.sv
// ms_timer: millisecond-granular settle timer for the key debouncer.
// Ports:
//   CLK          rising-edge clock
//   RSTn         asynchronous active-low reset
//   Clear        holds both counters at 0
//   Enable       advances the counters by one cycle
//   DEBOUNCE_MS  window length in ms (1..255)
//   Done         1-cycle strobe while the counters sit on the terminal value
module ms_timer
   import key_debounce_module_pkg::*;
#(
   parameter logic [15:0] T1MS = T1MS_50MHZ
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Clear,
   input  logic       Enable,
   input  logic [7:0] DEBOUNCE_MS,
   output logic       Done
);

   logic [15:0] count_1ms;
   logic [7:0]  count_ms;
   logic        tick_1ms;
   logic        last_ms;

   assign tick_1ms = (count_1ms == T1MS);
   assign last_ms  = (count_ms == (DEBOUNCE_MS - 8'd1));

   // Combinational so the FSM leaves its delay state on the same edge the
   // counters reach terminal; the owner registers everything it outputs.
   assign Done = Enable && !Clear && tick_1ms && last_ms;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         count_1ms <= 16'd0;
         count_ms  <= 8'd0;
      end else if (Clear) begin
         count_1ms <= 16'd0;
         count_ms  <= 8'd0;
      end else if (Enable) begin
         if (tick_1ms) begin
            count_1ms <= 16'd0;
            // Wrap at terminal so neither counter ever passes its end value.
            count_ms  <= last_ms ? 8'd0 : count_ms + 8'd1;
         end else begin
            count_1ms <= count_1ms + 16'd1;
         end
      end
   end

endmodule

// File: rtl/key_debounce_module.sv
// key_debounce_module: turns bouncy key edge strobes into one clean press
// event and one clean release event, with a fixed settle window after each
// accepted edge during which every strobe is treated as bounce.
// Ports:
//   CLK            rising-edge clock
//   RSTn           asynchronous active-low reset
//   H2L_Sig        1-cycle strobe, key pin fell (press)
//   L2H_Sig        1-cycle strobe, key pin rose (release)
//   Key_Down       debounced key level, 1 = pressed
//   Press_Pulse    1-cycle strobe, press accepted
//   Release_Pulse  1-cycle strobe, release accepted
//   Busy           1 while a settle window is running
//   State_Dbg      current FSM state (key_state_e encoding)
// Strobe semantics: an input strobe acts when it is high at a rising CLK edge;
// there is no back-pressure, a strobe the FSM does not want is simply dropped.
module key_debounce_module
   import key_debounce_module_pkg::*;
#(
   parameter logic [15:0] T1MS        = T1MS_50MHZ,
   parameter logic [7:0]  DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       H2L_Sig,
   input  logic       L2H_Sig,
   output logic       Key_Down,
   output logic       Press_Pulse,
   output logic       Release_Pulse,
   output logic       Busy,
   output logic [1:0] State_Dbg
);

   key_state_e state;
   key_state_e next_state;
   logic       in_delay;
   logic       timer_done;
   logic       press_next;
   logic       release_next;
   logic       key_down_next;
   logic       busy_next;

   assign in_delay  = (state == DLY_PRESS) || (state == DLY_RELEASE);
   assign State_Dbg = state;

   // Counters only run inside a window and sit at 0 everywhere else, so a
   // fresh window always starts from zero.
   ms_timer #(
      .T1MS (T1MS)
   ) u_ms_timer (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .Clear       (!in_delay),
      .Enable      (in_delay),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .Done        (timer_done)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      press_next    = 1'b0;
      release_next  = 1'b0;
      case (state)
         IDLE: begin
            if (H2L_Sig) next_state = DLY_PRESS;
         end
         DLY_PRESS: begin
            if (timer_done) begin
               next_state = PRESSED;
               press_next = 1'b1;
            end
         end
         PRESSED: begin
            if (L2H_Sig) next_state = DLY_RELEASE;
         end
         DLY_RELEASE: begin
            if (timer_done) begin
               next_state   = IDLE;
               release_next = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      // Outputs are derived from the state being entered so that, once
      // registered, they line up with that state's first cycle.
      key_down_next = (next_state == PRESSED) || (next_state == DLY_RELEASE);
      busy_next     = (next_state == DLY_PRESS) || (next_state == DLY_RELEASE);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         Key_Down      <= 1'b0;
         Press_Pulse   <= 1'b0;
         Release_Pulse <= 1'b0;
         Busy          <= 1'b0;
      end else begin
         Key_Down      <= key_down_next;
         Press_Pulse   <= press_next;
         Release_Pulse <= release_next;
         Busy          <= busy_next;
      end
   end

endmodule

// File: tb/tb_key_debounce_module.sv
module tb_key_debounce_module;

   localparam logic [15:0] P_T1MS = 16'd4;
   localparam logic [7:0]  P_DMS  = 8'd2;
   localparam int          N      = 10;   // 2 ms * 5 cycles per ms

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       h2l;
   logic       l2h;
   logic       key_down;
   logic       press_pulse;
   logic       release_pulse;
   logic       busy;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   key_debounce_module #(
      .T1MS        (P_T1MS),
      .DEBOUNCE_MS (P_DMS)
   ) dut (
      .CLK           (clk),
      .RSTn          (rst_n),
      .H2L_Sig       (h2l),
      .L2H_Sig       (l2h),
      .Key_Down      (key_down),
      .Press_Pulse   (press_pulse),
      .Release_Pulse (release_pulse),
      .Busy          (busy),
      .State_Dbg     (state_dbg)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int t0      = 0;
   int press_q[$];
   int rel_q[$];
   int busy_q[$];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc - t0);
      end
   endtask

   function automatic int count_in(input int q[$], input int lo, input int hi);
      int n = 0;
      foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
      return n;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   // The model remembers only the cycle of the last accepted edge and its
   // direction; every output follows from where the current cycle sits
   // relative to that accepted edge's window.
   int acc       = -1000;
   bit acc_press = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (press_pulse === 1'b1)   press_q.push_back(cyc);
         if (release_pulse === 1'b1) rel_q.push_back(cyc);
         if (busy === 1'b1)          busy_q.push_back(cyc);
         if (rst_n !== 1'b1) begin
            acc       = -1000;
            acc_press = 1'b0;
            check("rst_key_down", {7'd0, key_down}, 8'd0);
            check("rst_press", {7'd0, press_pulse}, 8'd0);
            check("rst_release", {7'd0, release_pulse}, 8'd0);
            check("rst_busy", {7'd0, busy}, 8'd0);
            check("rst_state", {6'd0, state_dbg}, 8'd0);
         end else begin
            bit settled, e_busy, e_key, e_pp, e_rp;
            logic [1:0] e_state;
            settled = (cyc > acc + N);
            e_busy  = !settled;
            e_key   = settled ? acc_press : !acc_press;
            e_pp    = acc_press && (cyc == acc + N + 1);
            e_rp    = !acc_press && (cyc == acc + N + 1);
            e_state = e_busy ? (acc_press ? 2'd1 : 2'd3) : (e_key ? 2'd2 : 2'd0);
            check("key_down", {7'd0, key_down}, {7'd0, e_key});
            check("press_pulse", {7'd0, press_pulse}, {7'd0, e_pp});
            check("release_pulse", {7'd0, release_pulse}, {7'd0, e_rp});
            check("busy", {7'd0, busy}, {7'd0, e_busy});
            check("state", {6'd0, state_dbg}, {6'd0, e_state});
            // Strobes present now are taken at the coming edge, only when no
            // window is running and only if they move the key level.
            if (settled) begin
               if (!e_key && h2l) begin
                  acc = cyc; acc_press = 1'b1;
               end else if (e_key && l2h) begin
                  acc = cyc; acc_press = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = cyc;
   endtask

   task automatic go_to(input int rel);
      while (cyc - t0 < rel) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic strobe(input logic h, input logic l);
      h2l = h; l2h = l;
      @(posedge clk); #1;
      h2l = 1'b0; l2h = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rst_n = 1'b0; h2l = 1'b0; l2h = 1'b0;

      // 1: idle after reset
      do_reset();
      go_to(50);
      check("t1_state", {6'd0, state_dbg}, 8'd0);
      check("t1_key_down", {7'd0, key_down}, 8'd0);
      check("t1_pulses", 8'(count_in(press_q, t0, t0 + 50) + count_in(rel_q, t0, t0 + 50)), 8'd0);
      check("t1_busy", 8'(count_in(busy_q, t0, t0 + 50)), 8'd0);

      // 2 + 4: clean press at 20, clean release at 40
      do_reset();
      go_to(20); strobe(1'b1, 1'b0);
      go_to(40); strobe(1'b0, 1'b1);
      go_to(60);
      check("t2_busy_21_30", 8'(count_in(busy_q, t0 + 21, t0 + 30)), 8'd10);
      check("t2_busy_total", 8'(count_in(busy_q, t0, t0 + 60)), 8'd20);
      check("t2_press_at_31", 8'(count_in(press_q, t0 + 31, t0 + 31)), 8'd1);
      check("t2_press_total", 8'(count_in(press_q, t0, t0 + 60)), 8'd1);
      check("t4_release_at_51", 8'(count_in(rel_q, t0 + 51, t0 + 51)), 8'd1);
      check("t4_release_total", 8'(count_in(rel_q, t0, t0 + 60)), 8'd1);
      check("t4_busy_41_50", 8'(count_in(busy_q, t0 + 41, t0 + 50)), 8'd10);
      check("t4_key_down", {7'd0, key_down}, 8'd0);

      // 3: bounce inside the press window
      do_reset();
      go_to(20); strobe(1'b1, 1'b0);
      go_to(23); strobe(1'b0, 1'b1);
      go_to(25); strobe(1'b1, 1'b0);
      go_to(27); strobe(1'b0, 1'b1);
      go_to(45);
      check("t3_press_at_31", 8'(count_in(press_q, t0 + 31, t0 + 31)), 8'd1);
      check("t3_press_total", 8'(count_in(press_q, t0, t0 + 45)), 8'd1);
      check("t3_release_total", 8'(count_in(rel_q, t0, t0 + 45)), 8'd0);
      check("t3_key_down", {7'd0, key_down}, 8'd1);

      // 5: reset in the middle of the press window
      do_reset();
      go_to(20); strobe(1'b1, 1'b0);
      go_to(25); rst_n = 1'b0;
      go_to(27); rst_n = 1'b1;
      check("t5_key_down_after_rst", {7'd0, key_down}, 8'd0);
      go_to(30); strobe(1'b1, 1'b0);
      go_to(50);
      check("t5_busy_21_24", 8'(count_in(busy_q, t0 + 21, t0 + 30)), 8'd4);
      check("t5_no_early_press", 8'(count_in(press_q, t0, t0 + 40)), 8'd0);
      check("t5_press_at_41", 8'(count_in(press_q, t0 + 41, t0 + 41)), 8'd1);
      check("t5_busy_31_40", 8'(count_in(busy_q, t0 + 31, t0 + 40)), 8'd10);

      // 6: ignored strobes and terminal-cycle boundaries
      do_reset();
      go_to(5);  strobe(1'b0, 1'b1);   // release while idle
      go_to(20); strobe(1'b1, 1'b0);   // press, terminal cycle 30
      go_to(30); strobe(1'b0, 1'b1);   // in terminal cycle: dropped
      go_to(33); strobe(1'b1, 1'b0);   // press while pressed: dropped
      go_to(35); strobe(1'b0, 1'b1);   // release, terminal cycle 45
      go_to(45); strobe(1'b1, 1'b0);   // in terminal cycle: dropped
      strobe(1'b1, 1'b0);              // cycle 46, right after: taken
      go_to(70);
      check("t6_idle_l2h_busy", 8'(count_in(busy_q, t0, t0 + 20)), 8'd0);
      check("t6_press_at_31", 8'(count_in(press_q, t0 + 31, t0 + 31)), 8'd1);
      check("t6_gap_busy_31_35", 8'(count_in(busy_q, t0 + 31, t0 + 35)), 8'd0);
      check("t6_busy_36_45", 8'(count_in(busy_q, t0 + 36, t0 + 45)), 8'd10);
      check("t6_release_at_46", 8'(count_in(rel_q, t0 + 46, t0 + 46)), 8'd1);
      check("t6_release_total", 8'(count_in(rel_q, t0, t0 + 70)), 8'd1);
      check("t6_press_at_57", 8'(count_in(press_q, t0 + 57, t0 + 57)), 8'd1);
      check("t6_press_total", 8'(count_in(press_q, t0, t0 + 70)), 8'd2);
      check("t6_key_down", {7'd0, key_down}, 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
